// File: rtl/hv_dvdt_tm_seq_if.sv
// Control/status bundle between the dvdt test-mode sequencer and its controller.
// The master drives requests and reads status; the slave is the sequencer.
interface hv_dvdt_tm_seq_if;
   logic       i_start;
   logic       i_abort;
   logic [1:0] i_mode_sel;
   logic       i_loop;
   logic [7:0] i_reg_dvdt_tm_sw;
   logic [7:0] o_reg_dvdt_tm;
   logic       o_busy;
   logic       o_done;

   modport master (
      output i_start, i_abort, i_mode_sel, i_loop, i_reg_dvdt_tm_sw,
      input  o_reg_dvdt_tm, o_busy, o_done
   );

   modport slave (
      input  i_start, i_abort, i_mode_sel, i_loop, i_reg_dvdt_tm_sw,
      output o_reg_dvdt_tm, o_busy, o_done
   );
endinterface

// File: rtl/hv_dvdt_tm_seq.sv
// dvdt test-mode sequencer: cap-trim (8'h80), guard gap (8'h00), cnt-del (8'h40), done pulse.
// Define HV_DVDT_SEQ_LOOP_EN to let DONE restart the latched sequence while i_loop is high.
module hv_dvdt_tm_seq #(
   parameter int unsigned CLK_M    = 48,
   parameter int unsigned DWELL_NS = 2500,
   parameter int unsigned GAP_NS   = 500
) (
   input logic               i_clk,
   input logic               i_rst_n,
   hv_dvdt_tm_seq_if.slave   bus
);

   localparam int unsigned DWELL_CYC = (DWELL_NS * CLK_M + 999) / 1000;
   localparam int unsigned GAP_CYC   = (GAP_NS * CLK_M + 999) / 1000;
   localparam int unsigned MAX_CYC   = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
   localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] DWELL_TERM = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_TERM   = CNT_W'(GAP_CYC - 1);

   if (DWELL_NS < 2100) begin : g_dwell_chk
      $error("DWELL_NS must be at least 2100 to cover the sampler capture window");
   end
   if (GAP_NS == 0) begin : g_gap_chk
      $error("GAP_NS must be non-zero");
   end

   typedef enum logic [2:0] {StIdle, StPh1, StGap, StPh2, StDone} state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_term;
   logic [1:0]       r_mode, w_mode_nxt;
   logic [7:0]       r_code, w_code_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;

`ifndef HV_DVDT_SEQ_LOOP_EN
   logic w_unused_loop;
   assign w_unused_loop = bus.i_loop;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_code_nxt  = 8'h00;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_term      = '0;

      unique case (r_state)
         StIdle: begin
            w_code_nxt = bus.i_reg_dvdt_tm_sw;
            if (bus.i_start && !bus.i_abort) begin
               w_mode_nxt = bus.i_mode_sel;
               if (bus.i_mode_sel[0])      w_state_nxt = StPh1;
               else if (bus.i_mode_sel[1]) w_state_nxt = StPh2;
               else                        w_state_nxt = StDone;
            end
         end
         StPh1: begin
            w_code_nxt = 8'h80;
            w_busy_nxt = 1'b1;
            w_term     = DWELL_TERM;
            if (r_cnt == DWELL_TERM) w_state_nxt = r_mode[1] ? StGap : StDone;
         end
         StGap: begin
            w_busy_nxt = 1'b1;
            w_term     = GAP_TERM;
            if (r_cnt == GAP_TERM) w_state_nxt = StPh2;
         end
         StPh2: begin
            w_code_nxt = 8'h40;
            w_busy_nxt = 1'b1;
            w_term     = DWELL_TERM;
            if (r_cnt == DWELL_TERM) w_state_nxt = StDone;
         end
         StDone: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = StIdle;
`ifdef HV_DVDT_SEQ_LOOP_EN
            if (bus.i_loop) begin
               if (r_mode[0])      w_state_nxt = StPh1;
               else if (r_mode[1]) w_state_nxt = StPh2;
            end
`endif
         end
         default: w_state_nxt = StIdle;
      endcase

      // Abort forces a clean 8'h00 cycle before the software value returns.
      if (bus.i_abort && r_state != StIdle) begin
         w_state_nxt = StIdle;
         w_code_nxt  = 8'h00;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
      end

      if (w_state_nxt != r_state) w_cnt_nxt = '0;
      else if (r_cnt != w_term)   w_cnt_nxt = r_cnt + CNT_W'(1);
      else                        w_cnt_nxt = r_cnt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_mode  <= 2'b00;
         r_code  <= 8'h00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
         r_code  <= w_code_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign bus.o_reg_dvdt_tm = r_code;
   assign bus.o_busy        = r_busy;
   assign bus.o_done        = r_done;

endmodule

// File: tb/tb_hv_dvdt_tm_seq.sv
// Self-checking bench for hv_dvdt_tm_seq: per-cycle expected trace held in a scoreboard queue.
// Phase lengths (120/24 cycles) are the default-parameter values written out independently.
module tb_hv_dvdt_tm_seq;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   hv_dvdt_tm_seq_if bus ();

   hv_dvdt_tm_seq dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] code;
      logic       busy;
      logic       done;
   } exp_t;

   typedef struct {
      logic [1:0] mode;
      logic [7:0] sw;
      int         n1;
      int         ng;
      int         n2;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] c, input logic b, input logic d);
      exp_t e;
      e.code = c;
      e.busy = b;
      e.done = d;
      sb.push_back(e);
   endtask

   task automatic push_seq(input int n1, input int ng, input int n2, input logic [7:0] sw,
                           input int tail);
      repeat (n1) push(8'h80, 1'b1, 1'b0);
      repeat (ng) push(8'h00, 1'b1, 1'b0);
      repeat (n2) push(8'h40, 1'b1, 1'b0);
      push(8'h00, 1'b0, 1'b1);
      repeat (tail) push(sw, 1'b0, 1'b0);
   endtask

   task automatic check_cycle(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard underflow, got code %0h, expected no more cycles", tag,
                  bus.o_reg_dvdt_tm);
         return;
      end
      e = sb.pop_front();
      chk({tag, " code"}, 32'(bus.o_reg_dvdt_tm), 32'(e.code));
      chk({tag, " busy"}, 32'(bus.o_busy), 32'(e.busy));
      chk({tag, " done"}, 32'(bus.o_done), 32'(e.done));
   endtask

   // Cycle k checks the outputs after edge T+k, then sets inputs sampled at edge T+k+1.
   task automatic run(input string tag, input int ncyc, input int start_at, input int abort_at,
                      input int mode_at, input logic [1:0] new_mode, input int loop_drop_at);
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk);
         #1;
         check_cycle(tag);
         bus.i_start = (k == start_at);
         bus.i_abort = (k == abort_at);
         if (k == mode_at) bus.i_mode_sel = new_mode;
         if (k == loop_drop_at) bus.i_loop = 1'b0;
      end
      chk({tag, " sb empty"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic kick(input logic [1:0] mode, input logic abort, input logic loop,
                       input logic [7:0] sw);
      bus.i_mode_sel       = mode;
      bus.i_start          = 1'b1;
      bus.i_abort          = abort;
      bus.i_loop           = loop;
      bus.i_reg_dvdt_tm_sw = sw;
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_abort = 1'b0;
   endtask

   vec_t tbl[4];

   initial begin
      tbl[0] = '{mode: 2'b11, sw: 8'h3C, n1: 120, ng: 24, n2: 120};
      tbl[1] = '{mode: 2'b10, sw: 8'hC3, n1: 0,   ng: 0,  n2: 120};
      tbl[2] = '{mode: 2'b01, sw: 8'h11, n1: 120, ng: 0,  n2: 0};
      tbl[3] = '{mode: 2'b00, sw: 8'hEE, n1: 0,   ng: 0,  n2: 0};

      bus.i_start          = 1'b0;
      bus.i_abort          = 1'b0;
      bus.i_mode_sel       = 2'b00;
      bus.i_loop           = 1'b0;
      bus.i_reg_dvdt_tm_sw = 8'h5A;

      // Reset held for three edges, then software value on the first edge after release.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("reset code", 32'(bus.o_reg_dvdt_tm), 32'h00);
         chk("reset busy", 32'(bus.o_busy), 32'd0);
         chk("reset done", 32'(bus.o_done), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset code", 32'(bus.o_reg_dvdt_tm), 32'h5A);
      chk("post-reset busy", 32'(bus.o_busy), 32'd0);

      foreach (tbl[i]) begin
         push_seq(tbl[i].n1, tbl[i].ng, tbl[i].n2, tbl[i].sw, 2);
         kick(tbl[i].mode, 1'b0, 1'b0, tbl[i].sw);
         run($sformatf("vec%0d", i), tbl[i].n1 + tbl[i].ng + tbl[i].n2 + 3, 0, 0, 0, 2'b00, 0);
      end

      // Abort at PH1 count 50 with a simultaneous start: 8'h00 once, then idle.
      repeat (50) push(8'h80, 1'b1, 1'b0);
      push(8'h00, 1'b0, 1'b0);
      repeat (5) push(8'h77, 1'b0, 1'b0);
      kick(2'b11, 1'b0, 1'b0, 8'h77);
      run("abort_ph1", 56, 50, 50, 0, 2'b00, 0);

      // Start re-pulsed at PH2 count 10 and mode changed mid-run: timing unchanged.
      push_seq(120, 24, 120, 8'h5A, 2);
      kick(2'b11, 1'b0, 1'b0, 8'h5A);
      bus.i_reg_dvdt_tm_sw = 8'h5A;
      run("restart_ph2", 267, 154, 0, 5, 2'b01, 0);

      // Abort landing in DONE suppresses the pulse.
      push(8'h00, 1'b0, 1'b0);
      repeat (2) push(8'h2B, 1'b0, 1'b0);
      kick(2'b00, 1'b0, 1'b0, 8'h2B);
      bus.i_abort = 1'b1;
      run("abort_done", 3, 0, 0, 0, 2'b00, 0);

      // Abort in IDLE blocks a simultaneous start.
      repeat (4) push(8'h99, 1'b0, 1'b0);
      kick(2'b11, 1'b1, 1'b0, 8'h99);
      run("abort_idle", 4, 0, 0, 0, 2'b00, 0);

      // Reset mid-sequence: outputs cleared, no done pulse.
      repeat (30) push(8'h80, 1'b1, 1'b0);
      kick(2'b11, 1'b0, 1'b0, 8'h42);
      run("pre_rst", 30, 0, 0, 0, 2'b00, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid-reset code", 32'(bus.o_reg_dvdt_tm), 32'h00);
      chk("mid-reset busy", 32'(bus.o_busy), 32'd0);
      chk("mid-reset done", 32'(bus.o_done), 32'd0);
      rst_n = 1'b1;
      repeat (3) push(8'h42, 1'b0, 1'b0);
      run("post_rst", 3, 0, 0, 0, 2'b00, 0);

`ifdef HV_DVDT_SEQ_LOOP_EN
      // Loop: second pass starts right after the first done; dropping i_loop ends it.
      push_seq(120, 24, 120, 8'h66, 0);
      push_seq(120, 24, 120, 8'h66, 2);
      kick(2'b11, 1'b0, 1'b1, 8'h66);
      run("loop", 532, 0, 0, 0, 2'b00, 300);
`else
      // Without the loop feature i_loop is ignored and DONE returns to IDLE.
      push_seq(120, 24, 120, 8'h66, 4);
      kick(2'b11, 1'b0, 1'b1, 8'h66);
      run("loop_ign", 269, 0, 0, 0, 2'b00, 0);
      bus.i_loop = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hv_dvdt_tm_seq.md
Name: hv_dvdt_tm_seq

Overview:
- Sequencer directly upstream of the angle-value sampler.
- On a start command it drives the 8-bit dvdt test-mode code through a timed sequence: cap-trim phase (8'h80), guard gap (8'h00), cnt-del phase (8'h40).
- Each phase is held long enough for the sampler's 2 us capture window to complete.
- When idle, the software register value passes straight through.

Parameters:
- CLK_M, 48, system clock frequency in MHz.
- DWELL_NS, 2500, hold time of each active phase in ns; elaboration error if < 2100.
- GAP_NS, 500, 8'h00 guard time between the two phases in ns; elaboration error if 0.
- Derived, not overridable: DWELL_CYC = (DWELL_NS*CLK_M+999)/1000 = 120; GAP_CYC = (GAP_NS*CLK_M+999)/1000 = 24; CNT_W = $clog2(max(DWELL_CYC,GAP_CYC)+1).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_start  input  1  start request, sampled in IDLE only.
- i_abort  input  1  abort request; has priority over i_start and over all state transitions.
- i_mode_sel  input  2  bit0 enables the cap-trim phase; bit1 enables the cnt-del phase. Latched at start.
- i_loop  input  1  repeat request; used only with the optional feature.
- i_reg_dvdt_tm_sw  input  8  software test-mode value, passed through in IDLE.
- o_reg_dvdt_tm  output  8  registered test-mode code to the sampler.
- o_busy  output  1  high in PH1, GAP and PH2.
- o_done  output  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset (i_rst_n=0 at a clock edge):
  - state=IDLE; counter=0; latched mode=0.
  - o_reg_dvdt_tm=8'h00, o_busy=0, o_done=0.
  - Reset applied mid-sequence has the same effect; no done pulse is generated.
- States: IDLE, PH1, GAP, PH2, DONE.
- IDLE:
  - o_reg_dvdt_tm <= i_reg_dvdt_tm_sw (1-cycle latency).
  - If i_start=1 and i_abort=0: latch i_mode_sel, clear the counter, then move to:
    - PH1 if mode bit0=1;
    - else PH2 if bit1=1;
    - else DONE.
- PH1:
  - o_reg_dvdt_tm=8'h80, held exactly DWELL_CYC cycles (counter 0..DWELL_CYC-1).
  - Exit to GAP if bit1=1, else to DONE. The counter clears on every state change.
- GAP:
  - o_reg_dvdt_tm=8'h00 for exactly GAP_CYC cycles, then go to PH2.
  - Prevents any direct 8'h80 -> 8'h40 transition.
- PH2:
  - o_reg_dvdt_tm=8'h40 for exactly DWELL_CYC cycles, then go to DONE.
- DONE:
  - Lasts one cycle: o_reg_dvdt_tm=8'h00, o_done=1, o_busy=0.
  - Then go to IDLE.
- Timing:
  - If start is sampled at edge T, the new state's output first appears at T+1.
  - Full sequence (mode 2'b11): 120 cycles of 8'h80, 24 cycles of 8'h00, 120 cycles of 8'h40, then done at cycle T+265.
- i_start while not in IDLE is ignored; it is not queued.
- i_abort=1 in PH1/GAP/PH2/DONE:
  - Next state is IDLE; counter clears.
  - The next cycle outputs 8'h00 (not the software value). The software value resumes one cycle after that.
  - o_done stays 0, including when abort lands in DONE, where it suppresses the pulse.
- i_abort in IDLE is a no-op, except that it blocks a simultaneous i_start.
- The counter never wraps: it saturates at its terminal value and clears on each state change.
- i_mode_sel and i_reg_dvdt_tm_sw changes during a sequence have no effect.

Optional Feature:
- Macro: HV_DVDT_SEQ_LOOP_EN.
- Defined: in DONE, if i_loop=1 and i_abort=0:
  - o_done still pulses.
  - Next state is the first enabled phase of the latched mode (PH1 or PH2), not IDLE.
  - With latched mode 0, return to IDLE.
- Undefined: i_loop is ignored and DONE always goes to IDLE.
- The port exists in both builds.

Test Plan:
- Reset check: hold i_rst_n=0 for 3 edges with i_reg_dvdt_tm_sw=8'h5A -> o_reg_dvdt_tm=8'h00, busy=0, done=0. After release, 8'h5A appears on the next edge.
- Full sequence, mode 2'b11, default parameters -> exactly 120x 8'h80, 24x 8'h00, 120x 8'h40, then done=1 for one cycle at T+265. Busy is high for cycles T+1..T+264.
- Single-phase modes:
  - mode 2'b10 -> 120x 8'h40, then done at T+121. No 8'h80 and no gap.
  - mode 2'b01 -> 120x 8'h80, then done at T+121.
  - mode 2'b00 -> done at T+1.
- Abort at PH1 counter=50 with start pulsed again simultaneously -> next cycle 8'h00, busy=0, no done; the following cycle shows the software value. The simultaneous start is ignored.
- Start re-pulsed at PH2 counter=10, and mode changed to 2'b01 mid-run -> sequence timing is unchanged. Done fires once at T+265.
- With HV_DVDT_SEQ_LOOP_EN, mode 2'b11, i_loop=1 -> done at T+265, then 8'h80 restarts at T+266. Dropping i_loop before the next DONE returns to IDLE after the second done.
